// File: rtl/vctrl_addr_seq.sv
// vctrl_addr_seq: walks the (row, col) tile space of one VArray run and
// emits one registered address beat per accepted cycle for the OBuf banks
// and for the channel-wise / element-wise EBuf and VBuf ports.
module vctrl_addr_seq #(
  parameter int VROW_LOOP  = 16,
  parameter int VCOL_LOOP  = 16,
  parameter int OBUF_BANK  = 8,
  parameter int OBUF_GRP   = 2,
  parameter int OBUF_DEPTH = 64,
  parameter int EBUF_BANK  = 4,
  parameter int EBUF_DEPTH = 256,
  parameter int VBUF_BANK  = 4,
  parameter int VBUF_DEPTH = 256
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic [$clog2(VROW_LOOP):0]                    cfg_rows,
  input  logic [$clog2(VCOL_LOOP):0]                    cfg_cols,
  input  logic [$clog2(EBUF_DEPTH)-1:0]                 cfg_ebase,
  input  logic [$clog2(VBUF_DEPTH)-1:0]                 cfg_vbase,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          out_last,
  output logic [OBUF_BANK*$clog2(OBUF_DEPTH)-1:0]       obuf_addr,
  output logic [OBUF_BANK-1:0]                          obuf_bank_sel,
  output logic [EBUF_BANK*$clog2(EBUF_DEPTH)-1:0]       cw_ebuf_addr,
  output logic [EBUF_BANK*$clog2(EBUF_DEPTH)-1:0]       ew_ebuf_addr,
  output logic [VBUF_BANK*$clog2(VBUF_DEPTH)-1:0]       cw_vbuf_addr,
  output logic [VBUF_BANK*$clog2(VBUF_DEPTH)-1:0]       ew_vbuf_addr
);

  localparam int RW  = $clog2(VROW_LOOP);
  localparam int CW  = $clog2(VCOL_LOOP);
  localparam int BPG = OBUF_BANK / OBUF_GRP;
  localparam int OAW = $clog2(OBUF_DEPTH);
  localparam int EAW = $clog2(EBUF_DEPTH);
  localparam int VAW = $clog2(VBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            st, st_nxt;
  logic [RW-1:0]     row_p0, row_nxt;
  logic [CW-1:0]     col_p0, col_nxt;
  logic [RW:0]       rows_q, rows_nxt;
  logic [CW:0]       cols_q, cols_nxt;
  logic [EAW-1:0]    ebase_q, ebase_nxt;
  logic [VAW-1:0]    vbase_q, vbase_nxt;
  logic              vld_nxt, last_nxt, row_end;

  logic [OBUF_BANK*OAW-1:0] obuf_addr_nxt;
  logic [OBUF_BANK-1:0]     sel_nxt;
  logic [EBUF_BANK*EAW-1:0] cw_e_nxt, ew_e_nxt;
  logic [VBUF_BANK*VAW-1:0] cw_v_nxt, ew_v_nxt;

  // Base + offset modulo the buffer depth; overflow wraps silently.
  function automatic int wrap_add(input int base, input int idx, input int depth);
    return (base + idx) % depth;
  endfunction

  // OBuf word for bank i of a group: {col, (s+i) mod BPG}, truncated to the bank depth.
  function automatic logic [OAW-1:0] obuf_word(input logic [RW-1:0] row,
                                               input logic [CW-1:0] col,
                                               input int i);
    int s;
    int shuf;
    s    = int'(row) / OBUF_GRP;
    shuf = (s + i) % BPG;
    return OAW'((int'(col) * BPG + shuf) % OBUF_DEPTH);
  endfunction

  assign busy    = (st != IDLE);
  assign row_end = ({1'b0, row_p0} == rows_q - (RW+1)'(1));

  // State, loop pointers and the per-run configuration snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      row_p0  <= '0;
      col_p0  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      ebase_q <= '0;
      vbase_q <= '0;
    end else begin
      st      <= st_nxt;
      row_p0  <= row_nxt;
      col_p0  <= col_nxt;
      rows_q  <= rows_nxt;
      cols_q  <= cols_nxt;
      ebase_q <= ebase_nxt;
      vbase_q <= vbase_nxt;
    end
  end

  // Next state, next pointers and next beat validity.
  always_comb begin
    st_nxt    = st;
    row_nxt   = row_p0;
    col_nxt   = col_p0;
    rows_nxt  = rows_q;
    cols_nxt  = cols_q;
    ebase_nxt = ebase_q;
    vbase_nxt = vbase_q;
    vld_nxt   = out_valid;
    case (st)
      IDLE: begin
        vld_nxt = 1'b0;
        row_nxt = '0;
        col_nxt = '0;
        if (!abort && start) begin
          rows_nxt  = cfg_rows;
          cols_nxt  = cfg_cols;
          ebase_nxt = cfg_ebase;
          vbase_nxt = cfg_vbase;
          if (cfg_rows == '0 || cfg_cols == '0) begin
            st_nxt = FIN;
          end else begin
            st_nxt  = RUN;
            vld_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          st_nxt  = IDLE;
          vld_nxt = 1'b0;
          row_nxt = '0;
          col_nxt = '0;
        end else if (out_valid && out_ready) begin
          if (out_last) begin
            st_nxt  = FIN;
            vld_nxt = 1'b0;
            row_nxt = '0;
            col_nxt = '0;
          end else if (row_end) begin
            row_nxt = '0;
            col_nxt = col_p0 + CW'(1);
          end else begin
            row_nxt = row_p0 + RW'(1);
          end
        end
      end
      FIN: begin
        st_nxt  = IDLE;
        vld_nxt = 1'b0;
        row_nxt = '0;
        col_nxt = '0;
      end
      default: begin
        st_nxt  = IDLE;
        vld_nxt = 1'b0;
        row_nxt = '0;
        col_nxt = '0;
      end
    endcase
  end

  // Address decode for the beat that will be presented next cycle.
  always_comb begin
    obuf_addr_nxt = '0;
    sel_nxt       = '0;
    cw_e_nxt      = '0;
    ew_e_nxt      = '0;
    cw_v_nxt      = '0;
    ew_v_nxt      = '0;
    last_nxt      = vld_nxt &&
                    ({1'b0, row_nxt} == rows_nxt - (RW+1)'(1)) &&
                    ({1'b0, col_nxt} == cols_nxt - (CW+1)'(1));
    for (int b = 0; b < OBUF_BANK; b++) begin
      obuf_addr_nxt[b*OAW +: OAW] = obuf_word(row_nxt, col_nxt, b % BPG);
      sel_nxt[b] = vld_nxt && ((b / BPG) == (int'(row_nxt) % OBUF_GRP));
    end
    for (int e = 0; e < EBUF_BANK; e++) begin
      cw_e_nxt[e*EAW +: EAW] = EAW'(row_nxt);
      ew_e_nxt[e*EAW +: EAW] = EAW'(wrap_add(int'(ebase_nxt), int'({col_nxt, row_nxt}), EBUF_DEPTH));
    end
    for (int v = 0; v < VBUF_BANK; v++) begin
      cw_v_nxt[v*VAW +: VAW] = VAW'(row_nxt);
      ew_v_nxt[v*VAW +: VAW] = VAW'(wrap_add(int'(vbase_nxt), int'({col_nxt, row_nxt}), VBUF_DEPTH));
    end
  end

  // ---- output register stage: every beat field leaves from a flop ----
  // Output beat registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      done          <= 1'b0;
      obuf_addr     <= '0;
      obuf_bank_sel <= '0;
      cw_ebuf_addr  <= '0;
      ew_ebuf_addr  <= '0;
      cw_vbuf_addr  <= '0;
      ew_vbuf_addr  <= '0;
    end else begin
      out_valid     <= vld_nxt;
      out_last      <= last_nxt;
      done          <= (st_nxt == FIN);
      obuf_addr     <= obuf_addr_nxt;
      obuf_bank_sel <= sel_nxt;
      cw_ebuf_addr  <= cw_e_nxt;
      ew_ebuf_addr  <= ew_e_nxt;
      cw_vbuf_addr  <= cw_v_nxt;
      ew_vbuf_addr  <= ew_v_nxt;
    end
  end

endmodule

// File: tb/tb_vctrl_addr_seq.sv
// Bench for vctrl_addr_seq: directed runs plus randomized runs checked
// against a beat-list reference model built from the addressing rules.
module tb_vctrl_addr_seq;

  localparam int M_FULL  = 0;
  localparam int M_BP    = 1;
  localparam int M_ABORT = 2;
  localparam int M_RAND  = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [4:0]  cfg_rows, cfg_cols;
  logic [7:0]  cfg_ebase, cfg_vbase;
  logic        busy, done, out_valid, out_last;
  logic [47:0] obuf_addr;
  logic [7:0]  obuf_bank_sel;
  logic [31:0] cw_ebuf_addr, ew_ebuf_addr, cw_vbuf_addr, ew_vbuf_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vctrl_addr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_ebase(cfg_ebase), .cfg_vbase(cfg_vbase),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .obuf_addr(obuf_addr), .obuf_bank_sel(obuf_bank_sel),
    .cw_ebuf_addr(cw_ebuf_addr), .ew_ebuf_addr(ew_ebuf_addr),
    .cw_vbuf_addr(cw_vbuf_addr), .ew_vbuf_addr(ew_vbuf_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 8 banks, 2 groups of 4, 64 words -> addr = (col*4 + (row/2 + i)%4) % 64.
  function automatic logic [47:0] m_obuf(input int r, input int c);
    logic [47:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) v[b*6 +: 6] = 6'((c*4 + ((r/2) + (b%4)) % 4) % 64);
    return v;
  endfunction

  function automatic logic [7:0] m_sel(input int r);
    logic [7:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) v[b] = ((b/4) == (r%2));
    return v;
  endfunction

  function automatic logic [31:0] m_rep(input int val);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(val % 256);
    return v;
  endfunction

  task automatic run(input int rows, input int cols, input int eb, input int vb, input int mode);
    int qr[$];
    int qc[$];
    int cyc, beats, hold, r, c;
    bit fin_pending, aborted, have_snap, rdy, timed_out;
    logic [63:0] snap;
    for (int cc = 0; cc < cols; cc++)
      for (int rr = 0; rr < rows; rr++) begin
        qr.push_back(rr);
        qc.push_back(cc);
      end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    cfg_rows = 5'(rows);
    cfg_cols = 5'(cols);
    cfg_ebase = 8'(eb);
    cfg_vbase = 8'(vb);
    fin_pending = (qr.size() == 0);
    cyc = 0; beats = 0; hold = 0;
    aborted = 1'b0; have_snap = 1'b0; timed_out = 1'b1;
    snap = '0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (aborted) begin
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        abort = 1'b0;
        timed_out = 1'b0;
        break;
      end
      chk("done", {63'd0, done}, {63'd0, fin_pending});
      if (fin_pending) begin
        chk("fin_valid", {63'd0, out_valid}, 64'd0);
        chk("beat_count", 64'(beats), 64'(rows*cols));
        timed_out = 1'b0;
        break;
      end
      r = qr[0];
      c = qc[0];
      chk("busy", {63'd0, busy}, 64'd1);
      chk("valid", {63'd0, out_valid}, 64'd1);
      chk("last", {63'd0, out_last}, {63'd0, qr.size() == 1});
      chk("obuf_addr", {16'd0, obuf_addr}, {16'd0, m_obuf(r, c)});
      chk("obuf_sel", {56'd0, obuf_bank_sel}, {56'd0, m_sel(r)});
      chk("cw_ebuf", {32'd0, cw_ebuf_addr}, {32'd0, m_rep(r)});
      chk("cw_vbuf", {32'd0, cw_vbuf_addr}, {32'd0, m_rep(r)});
      chk("ew_ebuf", {32'd0, ew_ebuf_addr}, {32'd0, m_rep(eb + c*16 + r)});
      chk("ew_vbuf", {32'd0, ew_vbuf_addr}, {32'd0, m_rep(vb + c*16 + r)});
      if (rows == 4 && r == 3 && c == 1) begin
        chk("shuffle_sel", {56'd0, obuf_bank_sel}, 64'hF0);
        chk("shuffle_bank4_7", {40'd0, obuf_addr[47:24]}, {40'd0, 6'd4, 6'd7, 6'd6, 6'd5});
      end
      if (eb == 250 && r == 10 && c == 0) begin
        chk("ew_wrap", {56'd0, ew_ebuf_addr[7:0]}, 64'd4);
        chk("cw_row", {56'd0, cw_ebuf_addr[7:0]}, 64'd10);
      end
      if (have_snap)
        chk("frozen", {obuf_bank_sel, ew_ebuf_addr[7:0], obuf_addr}, snap);
      rdy = 1'b1;
      case (mode)
        M_BP: if (beats == 1 && hold < 3) begin rdy = 1'b0; hold++; end
        M_RAND: rdy = ($urandom_range(0, 3) != 0);
        M_ABORT: if (beats == 2) begin abort = 1'b1; aborted = 1'b1; end
        default: rdy = 1'b1;
      endcase
      have_snap = !rdy && !aborted;
      snap = {obuf_bank_sel, ew_ebuf_addr[7:0], obuf_addr};
      out_ready = rdy;
      if (rdy && !aborted) begin
        void'(qr.pop_front());
        void'(qc.pop_front());
        beats++;
        if (qr.size() == 0) fin_pending = 1'b1;
      end
      if (mode == M_RAND && qr.size() > 0) begin
        start = 1'($urandom_range(0, 1));
        cfg_rows = 5'($urandom_range(0, 16));
        cfg_cols = 5'($urandom_range(0, 16));
        cfg_ebase = 8'($urandom);
      end
    end
    chk("run_timeout", {63'd0, timed_out}, 64'd0);
    if (mode == M_BP) chk("bp_hold_cycles", 64'(hold), 64'd3);
    @(negedge clk);
    chk("idle_after_run", {62'd0, busy, out_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_rows = '0; cfg_cols = '0; cfg_ebase = '0; cfg_vbase = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {60'd0, busy, done, out_valid, out_last}, 64'd0);
    chk("rst_obuf", {16'd0, obuf_addr}, 64'd0);
    chk("rst_sel", {56'd0, obuf_bank_sel}, 64'd0);
    chk("rst_ebuf", {cw_ebuf_addr, ew_ebuf_addr}, 64'd0);
    chk("rst_vbuf", {cw_vbuf_addr, ew_vbuf_addr}, 64'd0);
    rst_n = 1'b1;

    run(4, 2, 10, 20, M_FULL);
    run(4, 2, 5, 7, M_BP);
    run(16, 1, 250, 3, M_FULL);
    run(0, 3, 1, 1, M_FULL);
    run(4, 2, 9, 9, M_ABORT);
    run(4, 2, 9, 9, M_FULL);

    // Reset asserted mid-run while a beat is valid.
    @(negedge clk);
    start = 1'b1; cfg_rows = 5'd4; cfg_cols = 5'd2; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {60'd0, busy, done, out_valid, out_last}, 64'd0);
    chk("midrst_obuf", {8'd0, obuf_bank_sel, obuf_addr}, 64'd0);
    chk("midrst_ebuf", {cw_ebuf_addr, ew_ebuf_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++)
      run($urandom_range(1, 16), $urandom_range(1, 16),
          $urandom_range(0, 255), $urandom_range(0, 255), M_RAND);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
